// File: rtl/rca_cfg_if.sv
// rca_cfg_if: request, config-memory read and mux-write signals between the RCA config loader and its environment
interface rca_cfg_if #(
  parameter int NUM_RCAS       = 4,
  parameter int NUM_GRID_MUXES = 2,
  parameter int NUM_IO_UNITS   = 3,
  parameter int GRID_MUX_SEL_W = 3,
  parameter int IO_MUX_SEL_W   = 3,
  parameter int XLEN           = 32
);
  localparam int E   = 2*NUM_GRID_MUXES + NUM_IO_UNITS;
  localparam int AW  = $clog2(NUM_RCAS*E);
  localparam int IDW = $clog2(NUM_RCAS) + 1;
  localparam int RW  = $clog2(NUM_RCAS);
  localparam int GAW = $clog2(2*NUM_GRID_MUXES);
  localparam int IAW = $clog2(NUM_IO_UNITS);
  logic                      load_req;
  logic [IDW-1:0]            load_rca_id;
  logic                      ready;
  logic                      grid_busy;
  logic                      clear_fifos;
  logic                      cfg_rd_en;
  logic [AW-1:0]             cfg_rd_addr;
  logic [XLEN-1:0]           cfg_rd_data;
  logic                      grid_mux_wr_en;
  logic [GAW-1:0]            grid_mux_wr_addr;
  logic [GRID_MUX_SEL_W-1:0] new_grid_mux_sel;
  logic                      io_mux_wr_en;
  logic [IAW-1:0]            io_mux_addr;
  logic [IO_MUX_SEL_W-1:0]   new_io_mux_sel;
  logic                      load_done;
  logic                      load_err;
  logic [RW-1:0]             active_rca;
  logic                      config_valid;
  modport master (
    output load_req, load_rca_id, grid_busy, cfg_rd_data,
    input  ready, clear_fifos, cfg_rd_en, cfg_rd_addr, grid_mux_wr_en, grid_mux_wr_addr,
           new_grid_mux_sel, io_mux_wr_en, io_mux_addr, new_io_mux_sel, load_done, load_err,
           active_rca, config_valid
  );
  modport slave (
    input  load_req, load_rca_id, grid_busy, cfg_rd_data,
    output ready, clear_fifos, cfg_rd_en, cfg_rd_addr, grid_mux_wr_en, grid_mux_wr_addr,
           new_grid_mux_sel, io_mux_wr_en, io_mux_addr, new_io_mux_sel, load_done, load_err,
           active_rca, config_valid
  );
endinterface

// File: rtl/rca_config_loader.sv
// rca_config_loader: drains the grid, clears IO FIFOs and streams one RCA's mux selects from config memory
module rca_config_loader #(
  parameter int NUM_RCAS       = 4,
  parameter int NUM_GRID_MUXES = 2,
  parameter int NUM_IO_UNITS   = 3,
  parameter int GRID_MUX_SEL_W = 3,
  parameter int IO_MUX_SEL_W   = 3,
  parameter int XLEN           = 32
) (
  input logic    clk,
  input logic    rst,
  rca_cfg_if.slave bus
);
  localparam int G   = 2*NUM_GRID_MUXES;
  localparam int E   = G + NUM_IO_UNITS;
  localparam int AW  = $clog2(NUM_RCAS*E);
  localparam int IDW = $clog2(NUM_RCAS) + 1;
  localparam int RW  = $clog2(NUM_RCAS);
  localparam int GAW = $clog2(G);
  localparam int IAW = $clog2(NUM_IO_UNITS);
  localparam int KW  = $clog2(E + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] LOAD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]    state, nxt;
  logic [KW-1:0] k, wr_k;
  logic          wr_pend, load_err, config_valid, accept, id_ok;
  logic [AW-1:0] base;
  logic [RW-1:0] id, active_rca;
  always_comb begin
    accept = state == IDLE && bus.load_req;
    id_ok  = bus.load_rca_id < IDW'(NUM_RCAS);
    nxt    = state == IDLE  ? (accept && id_ok ? DRAIN : IDLE) :
             state == DRAIN ? (bus.grid_busy ? DRAIN : CLEAR) :
             state == CLEAR ? LOAD :
             state == LOAD  ? (k == KW'(E) ? DONE : LOAD) : IDLE;
  end
  // LOAD spends one extra cycle (k == E) so the last write lands before DONE
  always_ff @(posedge clk)
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      wr_k         <= '0;
      wr_pend      <= 1'b0;
      load_err     <= 1'b0;
      base         <= '0;
      id           <= '0;
      active_rca   <= '0;
      config_valid <= 1'b0;
    end else begin
      state    <= nxt;
      k        <= state == LOAD ? k + 1'b1 : '0;
      wr_pend  <= state == LOAD && k < KW'(E);
      wr_k     <= k;
      load_err <= accept && !id_ok;
      if (accept && id_ok) begin
        id   <= bus.load_rca_id[RW-1:0];
        base <= AW'(bus.load_rca_id * E);
      end
      if (state == DRAIN && !bus.grid_busy) config_valid <= 1'b0;
      if (state == DONE) begin
        active_rca   <= id;
        config_valid <= 1'b1;
      end
    end
  assign bus.ready            = state == IDLE;
  assign bus.clear_fifos      = state == CLEAR && !rst;
  assign bus.cfg_rd_en        = state == LOAD && k < KW'(E) && !rst;
  assign bus.cfg_rd_addr      = base + AW'(k);
  assign bus.grid_mux_wr_en   = wr_pend && wr_k < KW'(G) && !rst;
  assign bus.grid_mux_wr_addr = GAW'(wr_k);
  assign bus.new_grid_mux_sel = bus.cfg_rd_data[GRID_MUX_SEL_W-1:0];
  assign bus.io_mux_wr_en     = wr_pend && wr_k >= KW'(G) && !rst;
  assign bus.io_mux_addr      = IAW'(wr_k - KW'(G));
  assign bus.new_io_mux_sel   = bus.cfg_rd_data[IO_MUX_SEL_W-1:0];
  assign bus.load_done        = state == DONE && !rst;
  assign bus.load_err         = load_err;
  assign bus.active_rca       = active_rca;
  assign bus.config_valid     = config_valid;
endmodule
